// File: rtl/spi_flash_pkg.sv
// Shared opcodes and FSM state encoding for the SPI flash responder.
package spi_flash_pkg;

   localparam logic [7:0] OP_READ      = 8'h03;
   localparam logic [7:0] OP_FAST_READ = 8'h0B;
   localparam logic [7:0] OP_RDSR      = 8'h05;
   localparam logic [7:0] OP_RDID      = 8'h9F;

   typedef enum logic [3:0] {
      WAIT_CS_HIGH,
      IDLE,
      CMD,
      ADDR,
      DUMMY,
      DATA,
      ID,
      STAT,
      IGNORE
   } state_e;

endpackage

// File: rtl/spi_flash_responder_if.sv
// SPI pins, memory read port and command observation signals of the flash responder.
interface spi_flash_responder_if #(
   parameter int ADDR_W = 24
);
   logic              spi_cs;
   logic              spi_sck;
   logic              spi_mosi;
   logic              spi_miso;
   logic              spi_miso_oe;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rdata;
   logic              cmd_strobe;
   logic [7:0]        cmd_code;

   modport slave (
      input  spi_cs, spi_sck, spi_mosi, mem_rdata,
      output spi_miso, spi_miso_oe, mem_rd, mem_addr, cmd_strobe, cmd_code
   );

   modport master (
      output spi_cs, spi_sck, spi_mosi, mem_rdata,
      input  spi_miso, spi_miso_oe, mem_rd, mem_addr, cmd_strobe, cmd_code
   );
endinterface

// File: rtl/spi_edge_sync.sv
// Two-flop synchronisers for SCK/CS/MOSI plus edge pulses taken from the synchronised copies.
module spi_edge_sync (
   input  logic clk_i,
   input  logic reset_i,
   input  logic sck_i,
   input  logic cs_i,
   input  logic mosi_i,
   output logic sckRise_o,
   output logic sckFall_o,
   output logic csRise_o,
   output logic csFall_o,
   output logic csLevel_o,
   output logic mosiLevel_o
);
   logic [2:0] sck_q;
   logic [2:0] cs_q;
   logic [1:0] mosi_q;

   // CS resets low so a transaction still in flight after reset is never mistaken for idle.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sck_q  <= '0;
         cs_q   <= '0;
         mosi_q <= '0;
      end else begin
         sck_q  <= {sck_q[1:0], sck_i};
         cs_q   <= {cs_q[1:0], cs_i};
         mosi_q <= {mosi_q[0], mosi_i};
      end
   end

   assign sckRise_o   =  sck_q[1] & ~sck_q[2];
   assign sckFall_o   = ~sck_q[1] &  sck_q[2];
   assign csRise_o    =  cs_q[1]  & ~cs_q[2];
   assign csFall_o    = ~cs_q[1]  &  cs_q[2];
   assign csLevel_o   =  cs_q[1];
   assign mosiLevel_o =  mosi_q[1];
endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 NOR flash emulator: JEDEC ID, status read and data read from a 1-cycle memory port.
// Define SPI_FAST_READ_EN to accept opcode 0x0B with 8 dummy clocks.
module spi_flash_responder
   import spi_flash_pkg::*;
#(
   parameter int          ADDR_W     = 24,
   parameter logic [23:0] JEDEC_ID   = 24'hEF4016,
   parameter logic [7:0]  STATUS_VAL = 8'h00
) (
   input  logic                  clk_48mhz,
   input  logic                  reset,
   spi_flash_responder_if.slave  bus
);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   logic sckRise, sckFall, csRise, csFall, csLevel, mosiLevel;
   logic rise, fall, lastBit;
   logic [23:0] shiftNext;

   state_e            state_q, state_d;
   logic [2:0]        bitCnt_q;
   logic [1:0]        byteCnt_q;
   logic [23:0]       shiftIn_q;
   logic [7:0]        txShift_q;
   logic [7:0]        nextByte_q;
   logic              rdPend_q;
   logic              fast_q;
   logic              miso_q;
   logic              memRd_q;
   logic [ADDR_W-1:0] memAddr_q;
   logic              cmdStrobe_q;
   logic [7:0]        cmdCode_q;
   logic [7:0]        loadByte;
   logic              misoOe;

   spi_edge_sync u_sync (
      .clk_i       (clk_48mhz),
      .reset_i     (reset),
      .sck_i       (bus.spi_sck),
      .cs_i        (bus.spi_cs),
      .mosi_i      (bus.spi_mosi),
      .sckRise_o   (sckRise),
      .sckFall_o   (sckFall),
      .csRise_o    (csRise),
      .csFall_o    (csFall),
      .csLevel_o   (csLevel),
      .mosiLevel_o (mosiLevel)
   );

   assign rise      = sckRise & ~csLevel;
   assign fall      = sckFall & ~csLevel;
   assign lastBit   = (bitCnt_q == 3'd7);
   assign shiftNext = {shiftIn_q[22:0], mosiLevel};

   always_ff @(posedge clk_48mhz) begin
      if (reset) state_q <= WAIT_CS_HIGH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (csRise) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            WAIT_CS_HIGH: if (csLevel) state_d = IDLE;
            IDLE:         if (csFall) state_d = CMD;
            CMD: begin
               if (rise && lastBit) begin
                  case (shiftNext[7:0])
                     OP_RDID:      state_d = ID;
                     OP_RDSR:      state_d = STAT;
                     OP_READ:      state_d = ADDR;
`ifdef SPI_FAST_READ_EN
                     OP_FAST_READ: state_d = ADDR;
`endif
                     default:      state_d = IGNORE;
                  endcase
               end
            end
            ADDR:    if (rise && lastBit && byteCnt_q == 2'd2) state_d = fast_q ? DUMMY : DATA;
            DUMMY:   if (rise && lastBit) state_d = DATA;
            default: state_d = state_q;
         endcase
      end
   end

   // Byte presented at the next byte boundary, and whether MISO is being driven.
   always_comb begin
      loadByte = 8'h00;
      misoOe   = ~csLevel & ((state_q == DATA) | (state_q == ID) | (state_q == STAT));
      case (state_q)
         DATA: loadByte = nextByte_q;
         STAT: loadByte = STATUS_VAL;
         ID: begin
            case (byteCnt_q)
               2'd0:    loadByte = JEDEC_ID[23:16];
               2'd1:    loadByte = JEDEC_ID[15:8];
               2'd2:    loadByte = JEDEC_ID[7:0];
               default: loadByte = 8'h00;
            endcase
         end
         default: loadByte = 8'h00;
      endcase
   end

   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         bitCnt_q    <= '0;
         byteCnt_q   <= '0;
         shiftIn_q   <= '0;
         txShift_q   <= '0;
         nextByte_q  <= '0;
         rdPend_q    <= 1'b0;
         fast_q      <= 1'b0;
         miso_q      <= 1'b0;
         memRd_q     <= 1'b0;
         memAddr_q   <= '0;
         cmdStrobe_q <= 1'b0;
         cmdCode_q   <= '0;
      end else begin
         memRd_q     <= 1'b0;
         cmdStrobe_q <= 1'b0;
         rdPend_q    <= memRd_q;
         if (rdPend_q) nextByte_q <= bus.mem_rdata;
         if (csRise) begin
            bitCnt_q  <= '0;
            byteCnt_q <= '0;
            shiftIn_q <= '0;
            txShift_q <= '0;
            fast_q    <= 1'b0;
            miso_q    <= 1'b0;
         end else begin
            case (state_q)
               CMD: begin
                  if (rise) begin
                     shiftIn_q <= shiftNext;
                     bitCnt_q  <= bitCnt_q + 3'd1;
                     if (lastBit) begin
                        cmdStrobe_q <= 1'b1;
                        cmdCode_q   <= shiftNext[7:0];
                        fast_q      <= (shiftNext[7:0] == OP_FAST_READ);
                        byteCnt_q   <= '0;
                     end
                  end
               end
               ADDR: begin
                  if (rise) begin
                     shiftIn_q <= shiftNext;
                     bitCnt_q  <= bitCnt_q + 3'd1;
                     if (lastBit) begin
                        byteCnt_q <= (byteCnt_q == 2'd3) ? 2'd3 : byteCnt_q + 2'd1;
                        if (byteCnt_q == 2'd2) begin
                           memRd_q   <= 1'b1;
                           memAddr_q <= shiftNext[ADDR_W-1:0];
                        end
                     end
                  end
               end
               DUMMY: if (rise) bitCnt_q <= bitCnt_q + 3'd1;
               // Byte boundaries load a fresh byte; data reads prefetch the following address here.
               DATA, ID, STAT: begin
                  if (fall) begin
                     bitCnt_q <= bitCnt_q + 3'd1;
                     if (bitCnt_q == 3'd0) begin
                        miso_q    <= loadByte[7];
                        txShift_q <= {loadByte[6:0], 1'b0};
                        if (state_q == DATA) begin
                           memRd_q   <= 1'b1;
                           memAddr_q <= memAddr_q + ADDR_ONE;
                        end
                        if (state_q == ID) byteCnt_q <= (byteCnt_q == 2'd3) ? 2'd3 : byteCnt_q + 2'd1;
                     end else begin
                        miso_q    <= txShift_q[7];
                        txShift_q <= {txShift_q[6:0], 1'b0};
                     end
                  end
               end
               IGNORE:  miso_q <= 1'b0;
               default: ;
            endcase
         end
      end
   end

   assign bus.spi_miso    = miso_q;
   assign bus.spi_miso_oe = misoOe;
   assign bus.mem_rd      = memRd_q;
   assign bus.mem_addr    = memAddr_q;
   assign bus.cmd_strobe  = cmdStrobe_q;
   assign bus.cmd_code    = cmdCode_q;
endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: an SPI master driver plus a memory returning mem[n] = n[7:0].
module tb_spi_flash_responder;
   import spi_flash_pkg::*;

`ifdef SPI_FAST_READ_EN
   localparam logic [7:0] FAST_EXP = 8'h10;
`else
   localparam logic [7:0] FAST_EXP = 8'h00;
`endif

   logic clk = 1'b0;
   logic reset;
   int testCount = 0;
   int failCount = 0;
   int strobeCount = 0;
   int rdCount = 0;
   int rdAtRise = 0;
   int unstable = 0;
   int strobeBase;
   int rdBase;
   logic [23:0] rdAddr [16];
   logic [7:0] rx;

   spi_flash_responder_if #(.ADDR_W(24)) bus ();

   spi_flash_responder #(.ADDR_W(24)) dut (
      .clk_48mhz (clk),
      .reset     (reset),
      .bus       (bus)
   );

   always #10 clk = ~clk;

   // Memory with one cycle of read latency.
   always @(posedge clk) begin
      if (bus.mem_rd === 1'b1) bus.mem_rdata <= bus.mem_addr[7:0];
   end

   // Count strobes and record read addresses.
   always @(negedge clk) begin
      if (bus.cmd_strobe === 1'b1) strobeCount++;
      if (bus.mem_rd === 1'b1) begin
         if (rdCount < 16) rdAddr[rdCount] = bus.mem_addr;
         rdCount++;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // One SCK period: MOSI set while SCK low, MISO sampled at the rising edge and again mid-high.
   task automatic shiftBit(input logic mosiBit, output logic misoBit);
      bus.spi_mosi = mosiBit;
      #160;
      bus.spi_sck = 1'b1;
      misoBit = bus.spi_miso;
      rdAtRise = rdCount;
      #80;
      if (bus.spi_miso !== misoBit) unstable++;
      #80;
      bus.spi_sck = 1'b0;
   endtask

   task automatic applyStimulus(input logic [7:0] txByte, output logic [7:0] rxByte);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         shiftBit(txByte[i], b);
         rxByte[i] = b;
      end
   endtask

   task automatic csLow();
      bus.spi_cs = 1'b0;
      #200;
   endtask

   task automatic csHigh();
      #160;
      bus.spi_cs = 1'b1;
      #200;
   endtask

   initial begin
      logic b;
      reset = 1'b1;
      bus.spi_cs = 1'b1;
      bus.spi_sck = 1'b0;
      bus.spi_mosi = 1'b0;
      #105;
      checkOutput("rst_miso", 32'(bus.spi_miso), 32'h0);
      checkOutput("rst_oe", 32'(bus.spi_miso_oe), 32'h0);
      checkOutput("rst_mem_rd", 32'(bus.mem_rd), 32'h0);
      checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
      checkOutput("rst_strobe", 32'(bus.cmd_strobe), 32'h0);
      checkOutput("rst_cmd_code", 32'(bus.cmd_code), 32'h0);
      reset = 1'b0;
      #200;

      // JEDEC ID
      strobeBase = strobeCount;
      csLow();
      applyStimulus(OP_RDID, rx);
      applyStimulus(8'h00, rx);
      checkOutput("id_byte0", 32'(rx), 32'hEF);
      checkOutput("id_oe", 32'(bus.spi_miso_oe), 32'h1);
      applyStimulus(8'h00, rx);
      checkOutput("id_byte1", 32'(rx), 32'h40);
      applyStimulus(8'h00, rx);
      checkOutput("id_byte2", 32'(rx), 32'h16);
      applyStimulus(8'h00, rx);
      checkOutput("id_byte3", 32'(rx), 32'h00);
      csHigh();
      checkOutput("id_strobes", 32'(strobeCount - strobeBase), 32'd1);
      checkOutput("id_code", 32'(bus.cmd_code), 32'h9F);
      checkOutput("id_oe_after", 32'(bus.spi_miso_oe), 32'h0);

      // Read from 0x0001FE
      rdBase = rdCount;
      csLow();
      applyStimulus(OP_READ, rx);
      applyStimulus(8'h00, rx);
      applyStimulus(8'h01, rx);
      applyStimulus(8'hFE, rx);
      applyStimulus(8'h00, rx);
      checkOutput("rd_byte0", 32'(rx), 32'hFE);
      applyStimulus(8'h00, rx);
      checkOutput("rd_byte1", 32'(rx), 32'hFF);
      applyStimulus(8'h00, rx);
      checkOutput("rd_byte2", 32'(rx), 32'h00);
      applyStimulus(8'h00, rx);
      checkOutput("rd_byte3", 32'(rx), 32'h01);
      checkOutput("rd_pulses", 32'(rdAtRise - rdBase), 32'd5);
      checkOutput("rd_addr0", 32'(rdAddr[rdBase]), 32'h0001FE);
      checkOutput("rd_addr1", 32'(rdAddr[rdBase + 1]), 32'h0001FF);
      checkOutput("rd_addr4", 32'(rdAddr[rdBase + 4]), 32'h000202);
      checkOutput("rd_code", 32'(bus.cmd_code), 32'h03);
      checkOutput("rd_stable", 32'(unstable), 32'd0);
      csHigh();

      // Address wrap
      csLow();
      applyStimulus(OP_READ, rx);
      applyStimulus(8'hFF, rx);
      applyStimulus(8'hFF, rx);
      applyStimulus(8'hFF, rx);
      applyStimulus(8'h00, rx);
      checkOutput("wrap_byte0", 32'(rx), 32'hFF);
      applyStimulus(8'h00, rx);
      checkOutput("wrap_byte1", 32'(rx), 32'h00);
      checkOutput("wrap_addr", 32'(bus.mem_addr), 32'h000001);
      csHigh();

      // Abort after 5 opcode bits, then status read
      strobeBase = strobeCount;
      csLow();
      for (int i = 7; i >= 3; i--) shiftBit(OP_RDID[i], b);
      csHigh();
      checkOutput("abort_strobes", 32'(strobeCount - strobeBase), 32'd0);
      checkOutput("abort_oe", 32'(bus.spi_miso_oe), 32'h0);
      csLow();
      applyStimulus(OP_RDSR, rx);
      applyStimulus(8'hA5, rx);
      checkOutput("stat_byte0", 32'(rx), 32'h00);
      checkOutput("stat_oe", 32'(bus.spi_miso_oe), 32'h1);
      applyStimulus(8'h5A, rx);
      checkOutput("stat_byte1", 32'(rx), 32'h00);
      csHigh();
      checkOutput("stat_strobes", 32'(strobeCount - strobeBase), 32'd1);
      checkOutput("stat_code", 32'(bus.cmd_code), 32'h05);

      // Reset in the middle of a read with CS held low
      csLow();
      applyStimulus(OP_READ, rx);
      applyStimulus(8'h00, rx);
      applyStimulus(8'h00, rx);
      applyStimulus(8'h40, rx);
      applyStimulus(8'h00, rx);
      checkOutput("mid_byte0", 32'(rx), 32'h40);
      reset = 1'b1;
      #60;
      reset = 1'b0;
      #100;
      strobeBase = strobeCount;
      applyStimulus(OP_RDID, rx);
      applyStimulus(OP_RDID, rx);
      checkOutput("mid_miso", 32'(rx), 32'h00);
      checkOutput("mid_oe", 32'(bus.spi_miso_oe), 32'h0);
      checkOutput("mid_strobes", 32'(strobeCount - strobeBase), 32'd0);
      checkOutput("mid_code", 32'(bus.cmd_code), 32'h00);
      csHigh();
      csLow();
      applyStimulus(OP_RDID, rx);
      applyStimulus(8'h00, rx);
      checkOutput("mid_id_byte0", 32'(rx), 32'hEF);
      checkOutput("mid_id_strobes", 32'(strobeCount - strobeBase), 32'd1);
      csHigh();

      // Fast read (0x0B) from 0x000010 with 8 dummy clocks
      csLow();
      applyStimulus(OP_FAST_READ, rx);
      applyStimulus(8'h00, rx);
      applyStimulus(8'h00, rx);
      applyStimulus(8'h10, rx);
      applyStimulus(8'hFF, rx);
      checkOutput("fast_dummy", 32'(rx), 32'h00);
      applyStimulus(8'h00, rx);
      checkOutput("fast_byte0", 32'(rx), 32'(FAST_EXP));
      checkOutput("fast_code", 32'(bus.cmd_code), 32'h0B);
      csHigh();
      checkOutput("final_stable", 32'(unstable), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end
endmodule
